// File: rtl/video_sig_recover.sv
// video_sig_recover
//   Capture-side timing recovery. Measures line/frame geometry from a raw
//   h_sync / v_sync / active_draw stream, regenerates h_count / v_count
//   aligned to the first active pixel, and reports lock and timing errors.
//   All raster outputs trail the input stream by exactly two clocks.
//
//   Optional feature macro: VIDEO_SIG_RECOVER_FRAME_CNT_EN
//     When defined, adds parameter FPS and output frame_count[5:0], a
//     counter of locked frames that wraps at FPS and clears while unlocked.
//
//   Overflow is taken from the measurement counters: pixels since the last
//   h_sync rise and lines since the last v_sync rise. The output h_count
//   naturally runs long through vertical blanking, where it saturates
//   quietly, so it is not an error source on its own.
module video_sig_recover #(
  parameter int MAX_H_PIXELS = 2048,
  parameter int MAX_LINES    = 1024,
  parameter int LOCK_FRAMES  = 2,
`ifdef VIDEO_SIG_RECOVER_FRAME_CNT_EN
  parameter int FPS          = 60,
`endif
  localparam int H_W = $clog2(MAX_H_PIXELS),
  localparam int V_W = $clog2(MAX_LINES)
) (
  input  logic           pixel_clk,
  input  logic           rst_n,
  input  logic           h_sync_in,
  input  logic           v_sync_in,
  input  logic           active_draw_in,
  output logic [H_W-1:0] h_count,
  output logic [V_W-1:0] v_count,
  output logic           active_draw,
  output logic           locked,
  output logic           new_frame,
  output logic           timing_err,
  output logic [H_W-1:0] meas_h_total,
  output logic [H_W-1:0] meas_h_active,
  output logic [V_W-1:0] meas_v_total,
  output logic [V_W-1:0] meas_v_active
`ifdef VIDEO_SIG_RECOVER_FRAME_CNT_EN
  ,
  output logic [5:0]     frame_count
`endif
);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_MEASURE,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  localparam logic [H_W-1:0] H_SAT  = H_W'(MAX_H_PIXELS - 1);
  localparam logic [V_W-1:0] V_SAT  = V_W'(MAX_LINES - 1);
  localparam logic [3:0]     LOCK_N = 4'(LOCK_FRAMES);

  // input stage and edge detect
  logic r_hs_d, r_vs_d, r_ad_d;
  logic r_hs_q, r_vs_q, r_ad_q;
  logic w_hs_rise, w_vs_rise, w_ad_rise, w_ad_fall;

  // recovered raster
  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;
  logic           r_v_first;
  logic           r_ad_out;
  logic           w_v_load;

  // measurement counters and latched results
  logic [H_W-1:0] r_ht_cnt, r_ha_cnt;
  logic [V_W-1:0] r_vt_cnt, r_va_cnt;
  logic [H_W-1:0] r_meas_ht, r_meas_ha;
  logic [V_W-1:0] r_meas_vt, r_meas_va;
  logic [H_W-1:0] w_ht_nx, w_ha_nx;
  logic [V_W-1:0] w_vt_nx, w_va_nx, w_vt_inc;

  // lock tracking
  state_t         r_state, w_state_nx;
  logic [3:0]     r_match, w_match_nx;
  logic [H_W-1:0] r_ref_ht, r_ref_ha;
  logic [V_W-1:0] r_ref_vt, r_ref_va;
  logic           w_ref_ld, w_lose, w_frame_ok;
  logic           w_ovf_h, w_ovf_v, w_ovf;
  logic           r_locked, r_terr, r_nf;

  // Register the raw inputs once and keep the previous sample for edges
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
      r_ad_d <= 1'b0;
      r_hs_q <= 1'b0;
      r_vs_q <= 1'b0;
      r_ad_q <= 1'b0;
    end else begin
      r_hs_d <= h_sync_in;
      r_vs_d <= v_sync_in;
      r_ad_d <= active_draw_in;
      r_hs_q <= r_hs_d;
      r_vs_q <= r_vs_d;
      r_ad_q <= r_ad_d;
    end
  end

  assign w_hs_rise = r_hs_d & ~r_hs_q;
  assign w_vs_rise = r_vs_d & ~r_vs_q;
  assign w_ad_rise = r_ad_d & ~r_ad_q;
  assign w_ad_fall = ~r_ad_d & r_ad_q;

  // An active rise coincident with a v_sync rise opens the new frame
  assign w_v_load = w_ad_rise & (r_v_first | w_vs_rise);

  // Recovered h/v position, registered alongside the delayed active_draw
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_v_first <= 1'b0;
      r_ad_out  <= 1'b0;
    end else begin
      r_ad_out <= r_ad_d;
      if (w_ad_rise)
        r_h_cnt <= '0;
      else if (r_h_cnt != H_SAT)
        r_h_cnt <= r_h_cnt + H_W'(1);
      if (w_ad_rise)
        r_v_first <= 1'b0;
      else if (w_vs_rise)
        r_v_first <= 1'b1;
      if (w_v_load)
        r_v_cnt <= '0;
      else if (w_ad_rise && (r_v_cnt != V_SAT))
        r_v_cnt <= r_v_cnt + V_W'(1);
    end
  end

  // The coincident h_sync rise is counted into the frame that is closing
  assign w_vt_inc = (w_hs_rise && (r_vt_cnt != V_SAT)) ? r_vt_cnt + V_W'(1) : r_vt_cnt;

  // Values the meas_* registers take this cycle; the FSM compares these
  assign w_ht_nx = w_hs_rise ? r_ht_cnt : r_meas_ht;
  assign w_ha_nx = w_ad_fall ? r_ha_cnt : r_meas_ha;
  assign w_vt_nx = w_vs_rise ? w_vt_inc : r_meas_vt;
  assign w_va_nx = w_vs_rise ? r_va_cnt : r_meas_va;

  // Geometry counters, restarted on their own edges and saturating
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ht_cnt <= '0;
      r_ha_cnt <= '0;
      r_vt_cnt <= '0;
      r_va_cnt <= '0;
    end else begin
      if (w_hs_rise)
        r_ht_cnt <= H_W'(1);
      else if (r_ht_cnt != H_SAT)
        r_ht_cnt <= r_ht_cnt + H_W'(1);
      if (w_ad_rise)
        r_ha_cnt <= H_W'(1);
      else if (r_ad_d && (r_ha_cnt != H_SAT))
        r_ha_cnt <= r_ha_cnt + H_W'(1);
      if (w_vs_rise)
        r_vt_cnt <= '0;
      else
        r_vt_cnt <= w_vt_inc;
      if (w_vs_rise)
        r_va_cnt <= w_ad_rise ? V_W'(1) : '0;
      else if (w_ad_rise && (r_va_cnt != V_SAT))
        r_va_cnt <= r_va_cnt + V_W'(1);
    end
  end

  // Latch measurements on their edges; held otherwise
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meas_ht <= '0;
      r_meas_ha <= '0;
      r_meas_vt <= '0;
      r_meas_va <= '0;
    end else begin
      r_meas_ht <= w_ht_nx;
      r_meas_ha <= w_ha_nx;
      r_meas_vt <= w_vt_nx;
      r_meas_va <= w_va_nx;
    end
  end

  // Saturation is flagged once, on the clock the counter reaches the top
  assign w_ovf_h = ~w_hs_rise & (r_ht_cnt == H_SAT - H_W'(1));
  assign w_ovf_v = ~w_vs_rise & w_hs_rise & (r_vt_cnt == V_SAT - V_W'(1));
  assign w_ovf   = w_ovf_h | w_ovf_v;

  assign w_frame_ok = (w_ht_nx == r_ref_ht) && (w_ha_nx == r_ref_ha) &&
                      (w_vt_nx == r_ref_vt) && (w_va_nx == r_ref_va);

  // Lock FSM: next state, reference load and loss-of-lock decisions
  always_comb begin
    w_state_nx = r_state;
    w_match_nx = r_match;
    w_ref_ld   = 1'b0;
    w_lose     = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_vs_rise)
          w_state_nx = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (w_vs_rise) begin
          w_ref_ld   = 1'b1;
          w_match_nx = '0;
          w_state_nx = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (w_vs_rise) begin
          if (w_frame_ok) begin
            w_match_nx = r_match + 4'd1;
            if ((r_match + 4'd1) >= LOCK_N)
              w_state_nx = ST_LOCKED;
          end else begin
            w_ref_ld   = 1'b1;
            w_match_nx = '0;
          end
        end
      end
      ST_LOCKED: begin
        if ((w_hs_rise && (w_ht_nx != r_ref_ht)) || (w_vs_rise && !w_frame_ok)) begin
          w_lose     = 1'b1;
          w_state_nx = ST_SEARCH;
        end
      end
      default: w_state_nx = ST_SEARCH;
    endcase
    if (w_ovf)
      w_state_nx = ST_SEARCH;
  end

  // Lock FSM registers and the status pulses derived from it
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_SEARCH;
      r_match  <= '0;
      r_ref_ht <= '0;
      r_ref_ha <= '0;
      r_ref_vt <= '0;
      r_ref_va <= '0;
      r_locked <= 1'b0;
      r_terr   <= 1'b0;
      r_nf     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_match <= w_match_nx;
      if (w_ref_ld) begin
        r_ref_ht <= w_ht_nx;
        r_ref_ha <= w_ha_nx;
        r_ref_vt <= w_vt_nx;
        r_ref_va <= w_va_nx;
      end
      r_locked <= (w_state_nx == ST_LOCKED);
      r_terr   <= w_lose | w_ovf;
      r_nf     <= w_v_load & (w_state_nx == ST_LOCKED);
    end
  end

  assign h_count       = r_h_cnt;
  assign v_count       = r_v_cnt;
  assign active_draw   = r_ad_out;
  assign locked        = r_locked;
  assign new_frame     = r_nf;
  assign timing_err    = r_terr;
  assign meas_h_total  = r_meas_ht;
  assign meas_h_active = r_meas_ha;
  assign meas_v_total  = r_meas_vt;
  assign meas_v_active = r_meas_va;

`ifdef VIDEO_SIG_RECOVER_FRAME_CNT_EN
  logic [5:0] r_fcnt;

  // Count locked frames, step the clock after each new_frame pulse
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n)
      r_fcnt <= '0;
    else if (!r_locked)
      r_fcnt <= '0;
    else if (r_nf)
      r_fcnt <= (r_fcnt == 6'(FPS - 1)) ? 6'd0 : r_fcnt + 6'd1;
  end

  assign frame_count = r_fcnt;
`endif

endmodule

// File: tb/tb_video_sig_recover.sv
// Bench for video_sig_recover: a scaled-down raster source (40x12 totals,
// 32x9 active) drives the DUT; a table of pixel probes checks the recovered
// position, plus directed sequences for lock, loss of lock, reset and idle.
module tb_video_sig_recover;

  localparam int H_W   = 11;
  localparam int V_W   = 10;
  localparam int H_TOT = 40;
  localparam int H_ACT = 32;
  localparam int V_TOT = 12;
  localparam int V_ACT = 9;
  localparam int FRAME = H_TOT * V_TOT;

  logic           pixel_clk;
  logic           rst_n;
  logic           hs, vs, ad;
  logic [H_W-1:0] h_count;
  logic [V_W-1:0] v_count;
  logic           active_draw, locked, new_frame, timing_err;
  logic [H_W-1:0] meas_h_total, meas_h_active;
  logic [V_W-1:0] meas_v_total, meas_v_active;
`ifdef VIDEO_SIG_RECOVER_FRAME_CNT_EN
  logic [5:0]     frame_count;
`endif

  video_sig_recover #(
    .MAX_H_PIXELS(2048),
    .MAX_LINES   (1024),
    .LOCK_FRAMES (2)
`ifdef VIDEO_SIG_RECOVER_FRAME_CNT_EN
    ,
    .FPS         (4)
`endif
  ) dut (
    .pixel_clk     (pixel_clk),
    .rst_n         (rst_n),
    .h_sync_in     (hs),
    .v_sync_in     (vs),
    .active_draw_in(ad),
    .h_count       (h_count),
    .v_count       (v_count),
    .active_draw   (active_draw),
    .locked        (locked),
    .new_frame     (new_frame),
    .timing_err    (timing_err),
    .meas_h_total  (meas_h_total),
    .meas_h_active (meas_h_active),
    .meas_v_total  (meas_v_total),
    .meas_v_active (meas_v_active)
`ifdef VIDEO_SIG_RECOVER_FRAME_CNT_EN
    ,
    .frame_count   (frame_count)
`endif
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int checks   = 0;
  int failures = 0;

  // source state and 3-deep history of driven pixels (outputs trail by 2)
  int src_x, src_y, stretch_y;
  bit src_off;
  int hx0, hx1, hx2, hy0, hy1, hy2;
  int vs_seen, terr_cnt;

  typedef struct {
    int   x;
    int   y;
    int   h;
    int   v;
    logic ad;
    logic nf;
  } probe_t;
  probe_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // drive one pixel after the edge, advance the source, sample at negedge
  task automatic step();
    int len;
    @(posedge pixel_clk);
    #1;
    hx2 = hx1; hy2 = hy1;
    hx1 = hx0; hy1 = hy0;
    if (src_off) begin
      hs = 1'b0; vs = 1'b0; ad = 1'b0;
      hx0 = -1; hy0 = -1;
    end else begin
      ad = (src_x < H_ACT) && (src_y < V_ACT);
      hs = (src_x >= H_ACT + 2) && (src_x < H_ACT + 6);
      vs = (src_y == V_ACT + 1) || (src_y == V_ACT + 2);
      hx0 = src_x; hy0 = src_y;
      len = (src_y == stretch_y) ? H_TOT + 1 : H_TOT;
      if (src_x == len - 1) begin
        if (src_y == stretch_y) stretch_y = -1;
        src_x = 0;
        src_y = (src_y == V_TOT - 1) ? 0 : src_y + 1;
      end else begin
        src_x++;
      end
    end
    @(negedge pixel_clk);
    if (hx2 == 0 && hy2 == V_ACT + 1) vs_seen++;
    if (timing_err === 1'b1) terr_cnt++;
  endtask

  task automatic wait_pix(input int x, input int y, input string tag);
    int n = 0;
    while (!(hx2 == x && hy2 == y) && n < 2 * FRAME) begin
      step();
      n++;
    end
    check({tag, "_reached"}, 64'(hx2 == x && hy2 == y), 64'd1);
  endtask

  task automatic wait_lock(input string tag);
    int n = 0;
    while (locked !== 1'b1 && n < 10 * FRAME) begin
      step();
      n++;
    end
    check({tag, "_locked"}, 64'(locked), 64'd1);
    check({tag, "_vs_rises"}, 64'(vs_seen), 64'd4);
  endtask

  task automatic check_meas(input string tag);
    check({tag, "_h_total"}, 64'(meas_h_total), 64'(H_TOT));
    check({tag, "_h_active"}, 64'(meas_h_active), 64'(H_ACT));
    check({tag, "_v_total"}, 64'(meas_v_total), 64'(V_TOT));
    check({tag, "_v_active"}, 64'(meas_v_active), 64'(V_ACT));
  endtask

  task automatic wait_line(input int y);
    int n = 0;
    while (src_y != y && n < 2 * FRAME) begin
      step();
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {x, y, h_count, v_count, active_draw, new_frame} seen 2 cycles later
    tbl[0]  = '{0,  0, 0,   0, 1'b1, 1'b1};
    tbl[1]  = '{1,  0, 1,   0, 1'b1, 1'b0};
    tbl[2]  = '{31, 0, 31,  0, 1'b1, 1'b0};
    tbl[3]  = '{32, 0, 32,  0, 1'b0, 1'b0};
    tbl[4]  = '{39, 0, 39,  0, 1'b0, 1'b0};
    tbl[5]  = '{0,  1, 0,   1, 1'b1, 1'b0};
    tbl[6]  = '{5,  3, 5,   3, 1'b1, 1'b0};
    tbl[7]  = '{31, 8, 31,  8, 1'b1, 1'b0};
    tbl[8]  = '{0,  9, 40,  8, 1'b0, 1'b0};
    tbl[9]  = '{0, 11, 120, 8, 1'b0, 1'b0};
    tbl[10] = '{0,  0, 0,   0, 1'b1, 1'b1};

    rst_n = 1'b0;
    hs = 1'b0; vs = 1'b0; ad = 1'b0;
    src_x = 0; src_y = 0; stretch_y = -1; src_off = 1'b0;
    hx0 = -1; hx1 = -1; hx2 = -1; hy0 = -1; hy1 = -1; hy2 = -1;
    vs_seen = 0; terr_cnt = 0;

    // reset state
    repeat (3) step();
    check("reset_raster", 64'({h_count, v_count, active_draw, locked, new_frame, timing_err}), 64'd0);
    check("reset_meas", 64'({meas_h_total, meas_h_active, meas_v_total, meas_v_active}), 64'd0);
    rst_n = 1'b1;
    vs_seen = 0;

    // initial lock: locked rises on the 4th v_sync rise
    wait_lock("init");
    check_meas("init");

    // recovered raster position at chosen pixels
    for (int i = 0; i < 11; i++) begin
      wait_pix(tbl[i].x, tbl[i].y, $sformatf("probe%0d", i));
      check($sformatf("probe%0d_h", i), 64'(h_count), 64'(tbl[i].h));
      check($sformatf("probe%0d_v", i), 64'(v_count), 64'(tbl[i].v));
      check($sformatf("probe%0d_ad", i), 64'(active_draw), 64'(tbl[i].ad));
      check($sformatf("probe%0d_nf", i), 64'(new_frame), 64'(tbl[i].nf));
    end

    // one line stretched by a pixel: error at the following h_sync rise
    wait_line(V_ACT);
    stretch_y = 2;
    wait_pix(H_ACT + 1, 3, "stretch_pre");
    check("stretch_pre_locked", 64'(locked), 64'd1);
    check("stretch_pre_terr", 64'(timing_err), 64'd0);
    step();
    check("stretch_terr", 64'(timing_err), 64'd1);
    check("stretch_unlocked", 64'(locked), 64'd0);
    vs_seen = 0;
    step();
    check("stretch_terr_pulse", 64'(timing_err), 64'd0);
    wait_lock("relock_stretch");

`ifdef VIDEO_SIG_RECOVER_FRAME_CNT_EN
    // frame_count over five locked frames, then cleared by a lock loss
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      while (new_frame !== 1'b1 && n < 2 * FRAME) begin
        step();
        n++;
      end
      check($sformatf("fcnt_frame%0d", k), 64'(frame_count), 64'(k % 4));
      step();
    end
    wait_line(V_ACT);
    stretch_y = 2;
    begin
      int n = 0;
      while (timing_err !== 1'b1 && n < 2 * FRAME) begin
        step();
        n++;
      end
    end
    check("fcnt_loss_terr", 64'(timing_err), 64'd1);
    vs_seen = 0;
    step();
    check("fcnt_cleared", 64'(frame_count), 64'd0);
    wait_lock("relock_fcnt");
`endif

    // reset mid-frame while locked, then resync from scratch
    wait_pix(10, 4, "midrst_point");
    rst_n = 1'b0;
    step();
    check("midrst_raster", 64'({h_count, v_count, active_draw, locked, new_frame, timing_err}), 64'd0);
    check("midrst_meas", 64'({meas_h_total, meas_h_active, meas_v_total, meas_v_active}), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    vs_seen = 0;
    wait_lock("relock_rst");
    check_meas("relock_rst");

    // syncs stop: counters saturate, a single overflow error, lock dropped
    wait_pix(5, 1, "idle_point");
    check("idle_pre_locked", 64'(locked), 64'd1);
    src_off = 1'b1;
    terr_cnt = 0;
    repeat (2100) step();
    check("idle_terr_pulses", 64'(terr_cnt), 64'd1);
    check("idle_h_sat", 64'(h_count), 64'd2047);
    check("idle_unlocked", 64'(locked), 64'd0);
    check("idle_meas_hold", 64'(meas_h_total), 64'(H_TOT));
    check("idle_ad", 64'(active_draw), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
